pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage ARM-subset core. It sits beside the ID stage and drives its `hazard` input. It generates PC/IF-ID freeze and flush strobes, and freezes the whole pipeline while a multi-cycle data-memory access is outstanding. A timeout FSM and saturating stall/flush counters are included for debug.

---
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: RAW/branch hazard strobes, memory-wait freeze FSM with timeout,
// saturating stall/flush debug counters. Define PIPELINE_FORWARDING_EN when a forwarding unit is present.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_src1_used,
  input  logic             id_two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             exe_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             hazard,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t            state_r, state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_next_s;
  logic              timeout_set_s;
  logic              freeze_all_s;
  logic              raw_s;
  logic              mem_timeout_r;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;

  function automatic logic raw_match(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2,
                                     input logic u1, input logic u2);
    return (u1 && (s1 == d)) || (u2 && (s2 == d));
  endfunction

  // RAW detection: with forwarding only a load in EXE forces a bubble
  always_comb begin
    raw_s = 1'b0;
`ifdef PIPELINE_FORWARDING_EN
    raw_s = exe_wb_en && exe_mem_read &&
            raw_match(exe_dest, id_src1, id_src2, id_src1_used, id_two_src);
`else
    raw_s = (exe_wb_en && raw_match(exe_dest, id_src1, id_src2, id_src1_used, id_two_src)) ||
            (mem_wb_en && raw_match(mem_dest, id_src1, id_src2, id_src1_used, id_two_src));
`endif
  end

  // FSM next state, wait counter and pipeline-wide freeze
  always_comb begin
    state_next_s  = state_r;
    wait_next_s   = wait_cnt_r;
    timeout_set_s = 1'b0;
    freeze_all_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_next_s = ST_MEM_WAIT;
          wait_next_s  = WAIT_W'(1);
          freeze_all_s = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // Freeze drops in the completing cycle so an N-cycle stall freezes exactly N cycles
        if (mem_ready) begin
          state_next_s = ST_RUN;
          wait_next_s  = '0;
        end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
          state_next_s  = ST_HALT;
          timeout_set_s = 1'b1;
          freeze_all_s  = 1'b1;
        end else begin
          wait_next_s  = wait_cnt_r + WAIT_W'(1);
          freeze_all_s = 1'b1;
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
        freeze_all_s = 1'b1;
      end
      default: begin
        state_next_s = ST_HALT;
        freeze_all_s = 1'b1;
      end
    endcase
  end

  // FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_next_s;
      if (timeout_set_s) begin
        mem_timeout_r <= 1'b1;
      end else begin
        mem_timeout_r <= mem_timeout_r;
      end
    end
  end

  // Strobes; a taken branch overrides a RAW stall because the PC loads the target
  always_comb begin
    freeze_all   = freeze_all_s;
    hazard       = (raw_s || exe_branch_taken) && !freeze_all_s;
    freeze_pc    = (raw_s && !exe_branch_taken) || freeze_all_s;
    freeze_if_id = (raw_s && !exe_branch_taken) || freeze_all_s;
    flush_if_id  = exe_branch_taken && !freeze_all_s;
  end

  // Saturating debug counters, clear has priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else if (cnt_clr) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (freeze_pc && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_if_id && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign mem_timeout = mem_timeout_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: hazard vector table plus memory-stall,
// timeout, saturation and async-reset sequences. Built with CNT_W=4, MEM_TIMEOUT=4.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_src1_used, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
  logic       exe_branch_taken, mem_req, mem_ready, cnt_clr;
  logic       hazard, freeze_pc, freeze_if_id, flush_if_id, freeze_all, mem_timeout;
  logic [3:0] stall_cnt, flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef PIPELINE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  pipeline_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_src1_used(id_src1_used), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .exe_branch_taken(exe_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .hazard(hazard), .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
    .flush_if_id(flush_if_id), .freeze_all(freeze_all), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] src1;
    logic [3:0] src2;
    logic       u1;
    logic       two;
    logic [3:0] ed;
    logic       ewb;
    logic       emr;
    logic [3:0] md;
    logic       mwb;
    logic       br;
    logic       raw_nf;
    logic       raw_fw;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_src1 = 4'd0; id_src2 = 4'd0; id_src1_used = 1'b0; id_two_src = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; exe_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_src1 = v.src1; id_src2 = v.src2; id_src1_used = v.u1; id_two_src = v.two;
    exe_dest = v.ed; exe_wb_en = v.ewb; exe_mem_read = v.emr;
    mem_dest = v.md; mem_wb_en = v.mwb; exe_branch_taken = v.br;
  endtask

  task automatic clear_cnts();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    logic exp_raw;
    vecs[0]  = '{4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'd5, 4'd5, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{4'd5, 4'd5, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd0, 4'd9, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{4'd3, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'd1, 4'd7, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{4'd2, 4'd0, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state with idle inputs
    idle();
    rst = 1'b0;
    #2;
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_freeze_pc", {31'd0, freeze_pc}, 32'd0);
    chk("rst_flush", {31'd0, flush_if_id}, 32'd0);
    chk("rst_freeze_all", {31'd0, freeze_all}, 32'd0);
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("idle_freeze_all", {31'd0, freeze_all}, 32'd0);
    chk("idle_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    // Combinational strobe table
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
      exp_raw = FWD ? vecs[i].raw_fw : vecs[i].raw_nf;
      #2;
      chk($sformatf("v%0d_hazard", i), {31'd0, hazard}, {31'd0, exp_raw | vecs[i].br});
      chk($sformatf("v%0d_freeze_pc", i), {31'd0, freeze_pc}, {31'd0, exp_raw & ~vecs[i].br});
      chk($sformatf("v%0d_freeze_if_id", i), {31'd0, freeze_if_id}, {31'd0, exp_raw & ~vecs[i].br});
      chk($sformatf("v%0d_flush", i), {31'd0, flush_if_id}, {31'd0, vecs[i].br});
      chk($sformatf("v%0d_freeze_all", i), {31'd0, freeze_all}, 32'd0);
      tick();
    end
    idle();

    // Non-load EXE dependency: counts a stall only without forwarding
    clear_cnts();
    apply(vecs[1]);
    tick();
    idle();
    chk("exe_dep_stall_cnt", {28'd0, stall_cnt}, FWD ? 32'd0 : 32'd1);

    // Load-use plus taken branch in one cycle
    clear_cnts();
    apply(vecs[8]);
    #2;
    chk("lu_br_hazard", {31'd0, hazard}, 32'd1);
    chk("lu_br_flush", {31'd0, flush_if_id}, 32'd1);
    chk("lu_br_freeze_pc", {31'd0, freeze_pc}, 32'd0);
    tick();
    idle();
    chk("lu_br_flush_cnt", {28'd0, flush_cnt}, 32'd1);
    chk("lu_br_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    // mem_ready together with mem_req: no freeze, no state change
    clear_cnts();
    mem_req = 1'b1; mem_ready = 1'b1;
    #2;
    chk("mem_hit_freeze", {31'd0, freeze_all}, 32'd0);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    #2;
    chk("mem_hit_after", {31'd0, freeze_all}, 32'd0);
    tick();

    // 3-cycle memory stall with a branch waiting in EXE
    clear_cnts();
    mem_req = 1'b1; mem_ready = 1'b0; exe_branch_taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("mw%0d_freeze_all", c), {31'd0, freeze_all}, 32'd1);
      chk($sformatf("mw%0d_flush", c), {31'd0, flush_if_id}, 32'd0);
      chk($sformatf("mw%0d_hazard", c), {31'd0, hazard}, 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #2;
    chk("mw_done_freeze_all", {31'd0, freeze_all}, 32'd0);
    chk("mw_done_flush", {31'd0, flush_if_id}, 32'd1);
    chk("mw_done_freeze_pc", {31'd0, freeze_pc}, 32'd0);
    tick();
    idle();
    #2;
    chk("mw_back_run", {31'd0, freeze_all}, 32'd0);
    chk("mw_stall_cnt", {28'd0, stall_cnt}, 32'd3);
    chk("mw_flush_cnt", {28'd0, flush_cnt}, 32'd1);
    tick();

    // Stall counter saturation and clear priority
    clear_cnts();
    apply(vecs[2]);
    for (int c = 0; c < 20; c++) tick();
    chk("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_prio_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    idle();
    tick();

    // Async reset in the middle of MEM_WAIT
    clear_cnts();
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_stall_cnt", {28'd0, stall_cnt}, 32'd2);
    #2;
    rst = 1'b0;
    mem_req = 1'b0;
    #1;
    chk("async_rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("async_rst_freeze_all", {31'd0, freeze_all}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_freeze_all", {31'd0, freeze_all}, 32'd0);

    // Timeout with MEM_TIMEOUT=4: HALT and sticky flag
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("to_not_yet", {31'd0, mem_timeout}, 32'd0);
    tick();
    chk("to_set", {31'd0, mem_timeout}, 32'd1);
    mem_req = 1'b0; mem_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    #2;
    chk("halt_freeze_all", {31'd0, freeze_all}, 32'd1);
    chk("halt_timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    chk("halt_hazard", {31'd0, hazard}, 32'd0);
    idle();
    rst = 1'b0;
    #1;
    chk("halt_rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("halt_rst_freeze_all", {31'd0, freeze_all}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
